hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 148 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard control: ALU forwarding, load-use/branch bubbles, blocking-load wait
// with optional timeout, and a posted-store counter with ordering hold.
//
// state        | meaning
// ST_RUN       | pipeline flows; only store/order, branch and load-use rules apply
// ST_LOAD_WAIT | a load sits in M waiting for i_load_ack; whole pipe is held
module hazard_scoreboard #(
    parameter int MAX_STORES   = 2,
    parameter int ORDER_STRICT = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [4:0] i_e_rs1,
    input  logic [4:0] i_e_rs2,
    input  logic [4:0] i_m_rd,
    input  logic [4:0] i_w_rd,
    input  logic       i_m_regwrite,
    input  logic       i_w_regwrite,
    input  logic [1:0] i_m_result_src,
    output logic [1:0] o_fwd_a,
    output logic [1:0] o_fwd_b,
    input  logic [4:0] i_d_rs1,
    input  logic [4:0] i_d_rs2,
    input  logic       i_d_use_rs1,
    input  logic       i_d_use_rs2,
    input  logic [4:0] i_e_rd,
    input  logic       i_e_load,
    input  logic       i_e_store,
    input  logic       i_load_ack,
    input  logic       i_store_ack,
    input  logic       i_e_pc_src,
    output logic       o_f_stall,
    output logic       o_fd_stall,
    output logic       o_de_stall,
    output logic       o_em_stall,
    output logic       o_fd_flush,
    output logic       o_de_flush,
    output logic       o_em_flush,
    output logic       o_mw_flush,
    output logic [3:0] o_store_cnt,
    output logic       o_bus_timeout
);

    typedef enum logic {ST_RUN = 1'b0, ST_LOAD_WAIT = 1'b1} state_t;

    localparam logic [3:0]  MAX_CNT   = 4'(MAX_STORES);
    localparam logic        TO_EN     = (TIMEOUT != 0);
    localparam logic [15:0] WAIT_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);
    localparam logic        ORDER_EN  = (ORDER_STRICT != 0);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_wait_cnt;
    logic [3:0]  r_store_cnt;

    logic w_in_wait, w_timeout, w_hold, w_store_full, w_order, w_load_use;
    logic w_load_enter, w_store_inc, w_store_dec;
    logic w_m_hit_a, w_w_hit_a, w_m_hit_b, w_w_hit_b;
    logic [1:0] w_m_sel;

    // Forwarding: M wins over W; an M-stage extend result gets its own select.
    assign w_m_sel   = (i_m_result_src == 2'b11) ? 2'b11 : 2'b10;
    assign w_m_hit_a = (i_e_rs1 != 5'd0) && i_m_regwrite && (i_e_rs1 == i_m_rd);
    assign w_w_hit_a = (i_e_rs1 != 5'd0) && i_w_regwrite && (i_e_rs1 == i_w_rd);
    assign w_m_hit_b = (i_e_rs2 != 5'd0) && i_m_regwrite && (i_e_rs2 == i_m_rd);
    assign w_w_hit_b = (i_e_rs2 != 5'd0) && i_w_regwrite && (i_e_rs2 == i_w_rd);
    assign o_fwd_a   = w_m_hit_a ? w_m_sel : (w_w_hit_a ? 2'b01 : 2'b00);
    assign o_fwd_b   = w_m_hit_b ? w_m_sel : (w_w_hit_b ? 2'b01 : 2'b00);

    assign w_in_wait    = (r_state == ST_LOAD_WAIT);
    assign w_timeout    = TO_EN && w_in_wait && !i_load_ack && (r_wait_cnt == WAIT_LAST);
    assign w_hold       = w_in_wait && !i_load_ack && !w_timeout;
    assign w_store_full = i_e_store && (r_store_cnt == MAX_CNT) && !i_store_ack;
    assign w_order      = ORDER_EN && i_e_load && (r_store_cnt != 4'd0);
    assign w_load_use   = i_e_load && (i_e_rd != 5'd0) &&
                          ((i_d_use_rs1 && (i_d_rs1 == i_e_rd)) ||
                           (i_d_use_rs2 && (i_d_rs2 == i_e_rd)));

    always_comb begin
        o_f_stall     = 1'b0;
        o_fd_stall    = 1'b0;
        o_de_stall    = 1'b0;
        o_em_stall    = 1'b0;
        o_fd_flush    = 1'b0;
        o_de_flush    = 1'b0;
        o_em_flush    = 1'b0;
        o_mw_flush    = 1'b0;
        o_bus_timeout = 1'b0;
        if (i_rst) begin
            o_bus_timeout = w_timeout;
            if (w_hold) begin
                o_f_stall  = 1'b1;
                o_fd_stall = 1'b1;
                o_de_stall = 1'b1;
                o_em_stall = 1'b1;
                o_mw_flush = 1'b1;
            end else if (w_store_full || w_order) begin
                o_f_stall  = 1'b1;
                o_fd_stall = 1'b1;
                o_de_stall = 1'b1;
                o_em_flush = 1'b1;
            end else if (i_e_pc_src) begin
                o_fd_flush = 1'b1;
                o_de_flush = 1'b1;
            end else if (w_load_use) begin
                o_f_stall  = 1'b1;
                o_fd_stall = 1'b1;
                o_de_flush = 1'b1;
            end
        end
    end

    // E advances into M whenever the D/E register is not held.
    assign w_load_enter = i_e_load && !o_de_stall;
    assign w_store_inc  = i_e_store && !o_de_stall && (r_store_cnt != 4'hF);
    assign w_store_dec  = i_store_ack && (r_store_cnt != 4'd0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:       if (w_load_enter) w_state_nxt = ST_LOAD_WAIT;
            ST_LOAD_WAIT: if (!w_hold) w_state_nxt = w_load_enter ? ST_LOAD_WAIT : ST_RUN;
            default:      w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= 16'd0;
            r_store_cnt <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_enter)
                r_wait_cnt <= 16'd0;
            else if (w_in_wait && (r_wait_cnt != 16'hFFFF))
                r_wait_cnt <= r_wait_cnt + 16'd1;
            if (w_store_inc && !w_store_dec)
                r_store_cnt <= r_store_cnt + 4'd1;
            else if (w_store_dec && !w_store_inc)
                r_store_cnt <= r_store_cnt - 4'd1;
        end
    end

    assign o_store_cnt = r_store_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard (MAX_STORES=2, ORDER_STRICT=1, TIMEOUT=4):
// hand-derived expectations are queued with each stimulus and checked at the falling edge.
module tb_hazard_scoreboard;

    logic       clk;
    logic       rst;
    logic [4:0] e_rs1, e_rs2, m_rd, w_rd, d_rs1, d_rs2, e_rd;
    logic       m_rw, w_rw, d_use1, d_use2, e_load, e_store, load_ack, store_ack, pc_src;
    logic [1:0] m_src;
    logic [1:0] fwd_a, fwd_b;
    logic       f_stall, fd_stall, de_stall, em_stall, fd_flush, de_flush, em_flush, mw_flush;
    logic       bus_to;
    logic [3:0] store_cnt;
    logic [8:0] ctrl;

    typedef struct packed {
        logic [8:0] ctrl;
        logic [3:0] fwd;
        logic [3:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // ctrl = {f_stall, fd_stall, de_stall, em_stall, fd_flush, de_flush, em_flush, mw_flush, timeout}
    localparam logic [8:0] C_NONE = 9'b0000_0000_0;
    localparam logic [8:0] C_HOLD = 9'b1111_0001_0;
    localparam logic [8:0] C_SF   = 9'b1110_0010_0;
    localparam logic [8:0] C_BR   = 9'b0000_1100_0;
    localparam logic [8:0] C_LU   = 9'b1100_0100_0;
    localparam logic [8:0] C_TO   = 9'b0000_0000_1;

    hazard_scoreboard #(.MAX_STORES(2), .ORDER_STRICT(1), .TIMEOUT(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_e_rs1(e_rs1), .i_e_rs2(e_rs2), .i_m_rd(m_rd), .i_w_rd(w_rd),
        .i_m_regwrite(m_rw), .i_w_regwrite(w_rw), .i_m_result_src(m_src),
        .o_fwd_a(fwd_a), .o_fwd_b(fwd_b),
        .i_d_rs1(d_rs1), .i_d_rs2(d_rs2), .i_d_use_rs1(d_use1), .i_d_use_rs2(d_use2),
        .i_e_rd(e_rd), .i_e_load(e_load), .i_e_store(e_store),
        .i_load_ack(load_ack), .i_store_ack(store_ack), .i_e_pc_src(pc_src),
        .o_f_stall(f_stall), .o_fd_stall(fd_stall), .o_de_stall(de_stall), .o_em_stall(em_stall),
        .o_fd_flush(fd_flush), .o_de_flush(de_flush), .o_em_flush(em_flush), .o_mw_flush(mw_flush),
        .o_store_cnt(store_cnt), .o_bus_timeout(bus_to)
    );

    assign ctrl = {f_stall, fd_stall, de_stall, em_stall, fd_flush, de_flush, em_flush, mw_flush, bus_to};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clr_inputs();
        e_rs1 = 0; e_rs2 = 0; m_rd = 0; w_rd = 0; d_rs1 = 0; d_rs2 = 0; e_rd = 0;
        m_rw = 0; w_rw = 0; m_src = 0; d_use1 = 0; d_use2 = 0;
        e_load = 0; e_store = 0; load_ack = 0; store_ack = 0; pc_src = 0;
    endtask

    // Called just after a rising edge with inputs already applied.
    task automatic step(input string tag, input logic [8:0] c, input logic [1:0] fa,
                        input logic [1:0] fb, input logic [3:0] cnt);
        exp_t e;
        exp_q.push_back('{ctrl: c, fwd: {fa, fb}, cnt: cnt});
        @(negedge clk);
        e = exp_q.pop_front();
        check_eq({tag, ".ctrl"}, 16'(ctrl), 16'(e.ctrl));
        check_eq({tag, ".fwd"}, 16'({fwd_a, fwd_b}), 16'(e.fwd));
        check_eq({tag, ".cnt"}, 16'(store_cnt), 16'(e.cnt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        clr_inputs();
        @(posedge clk);
        #1;
        // outputs forced low in reset even with a load-use pattern; forwarding stays live
        e_load = 1; e_rd = 5; d_rs1 = 5; d_use1 = 1;
        e_rs1 = 3; m_rd = 3; m_rw = 1;
        step("reset", C_NONE, 2'b10, 2'b00, 4'd0);
        clr_inputs();
        rst = 1'b1;

        // forwarding
        e_rs1 = 3; m_rd = 3; m_rw = 1; e_rs2 = 4; w_rd = 4; w_rw = 1;
        step("fwd_m_w", C_NONE, 2'b10, 2'b01, 4'd0);
        m_src = 2'b11;
        step("fwd_ext", C_NONE, 2'b11, 2'b01, 4'd0);
        clr_inputs();
        m_rw = 1; w_rw = 0; e_rs2 = 7; w_rd = 7;
        step("fwd_x0_nowr", C_NONE, 2'b00, 2'b00, 4'd0);
        e_rs1 = 9; e_rs2 = 9; m_rd = 9; w_rd = 9; m_rw = 1; w_rw = 1; m_src = 2'b00;
        step("fwd_prio", C_NONE, 2'b10, 2'b10, 4'd0);
        m_rw = 0;
        step("fwd_w_only", C_NONE, 2'b01, 2'b01, 4'd0);
        clr_inputs();

        // load-use then load wait, then W forward
        e_load = 1; e_rd = 5; d_rs1 = 5; d_use1 = 1; d_rs2 = 1; d_use2 = 1;
        step("lu", C_LU, 2'b00, 2'b00, 4'd0);
        clr_inputs();
        m_rd = 5; m_rw = 1; m_src = 2'b11;
        step("lu_wait", C_HOLD, 2'b00, 2'b00, 4'd0);
        load_ack = 1;
        step("lu_ack", C_NONE, 2'b00, 2'b00, 4'd0);
        clr_inputs();
        e_rs1 = 5; e_rs2 = 1; w_rd = 5; w_rw = 1;
        step("lu_fwd_w", C_NONE, 2'b01, 2'b00, 4'd0);
        clr_inputs();

        // x0 destination and unused source never load-use stall
        e_load = 1; e_rd = 0; d_rs1 = 0; d_use1 = 1; d_rs2 = 6; d_use2 = 0;
        step("lu_x0", C_NONE, 2'b00, 2'b00, 4'd0);
        clr_inputs();
        load_ack = 1;
        step("lu_x0_ack", C_NONE, 2'b00, 2'b00, 4'd0);
        clr_inputs();

        // ack after three hold cycles
        e_load = 1; e_rd = 8;
        step("ld_enter", C_NONE, 2'b00, 2'b00, 4'd0);
        clr_inputs();
        for (int i = 0; i < 3; i++) step("ld_hold", C_HOLD, 2'b00, 2'b00, 4'd0);
        load_ack = 1;
        step("ld_ack4", C_NONE, 2'b00, 2'b00, 4'd0);
        clr_inputs();
        step("ld_run", C_NONE, 2'b00, 2'b00, 4'd0);

        // timeout: three holds then pulse in the fourth wait cycle
        e_load = 1; e_rd = 8;
        step("to_enter", C_NONE, 2'b00, 2'b00, 4'd0);
        clr_inputs();
        for (int i = 0; i < 3; i++) step("to_hold", C_HOLD, 2'b00, 2'b00, 4'd0);
        step("to_pulse", C_TO, 2'b00, 2'b00, 4'd0);
        step("to_run", C_NONE, 2'b00, 2'b00, 4'd0);

        // branch overrides load-use; deferred during a hold
        pc_src = 1; e_load = 1; e_rd = 5; d_rs1 = 5; d_use1 = 1;
        step("br_lu", C_BR, 2'b00, 2'b00, 4'd0);
        clr_inputs();
        pc_src = 1;
        step("br_deferred", C_HOLD, 2'b00, 2'b00, 4'd0);
        load_ack = 1;
        step("br_on_ack", C_BR, 2'b00, 2'b00, 4'd0);
        clr_inputs();

        // posted stores, full hold, ordering, ack boundaries
        e_store = 1;
        step("st1", C_NONE, 2'b00, 2'b00, 4'd0);
        step("st2", C_NONE, 2'b00, 2'b00, 4'd1);
        step("st3_full", C_SF, 2'b00, 2'b00, 4'd2);
        step("st3_full2", C_SF, 2'b00, 2'b00, 4'd2);
        store_ack = 1;
        step("st3_ack", C_NONE, 2'b00, 2'b00, 4'd2);
        clr_inputs();
        step("st_keep2", C_NONE, 2'b00, 2'b00, 4'd2);
        e_load = 1; e_rd = 9;
        step("order", C_SF, 2'b00, 2'b00, 4'd2);
        pc_src = 1;
        step("order_vs_br", C_SF, 2'b00, 2'b00, 4'd2);
        clr_inputs();
        store_ack = 1;
        step("sack1", C_NONE, 2'b00, 2'b00, 4'd2);
        step("sack2", C_NONE, 2'b00, 2'b00, 4'd1);
        step("sack_at0", C_NONE, 2'b00, 2'b00, 4'd0);
        clr_inputs();
        step("no_wrap", C_NONE, 2'b00, 2'b00, 4'd0);

        // reset with stores pending
        e_store = 1;
        step("rs_st1", C_NONE, 2'b00, 2'b00, 4'd0);
        step("rs_st2", C_NONE, 2'b00, 2'b00, 4'd1);
        rst = 1'b0;
        step("rs_cnt", C_NONE, 2'b00, 2'b00, 4'd0);
        rst = 1'b1;
        clr_inputs();
        step("rs_after", C_NONE, 2'b00, 2'b00, 4'd0);

        // reset mid load wait, then a load with immediate ack
        e_load = 1; e_rd = 8;
        step("rw_enter", C_NONE, 2'b00, 2'b00, 4'd0);
        clr_inputs();
        step("rw_hold", C_HOLD, 2'b00, 2'b00, 4'd0);
        rst = 1'b0;
        step("rw_reset", C_NONE, 2'b00, 2'b00, 4'd0);
        rst = 1'b1;
        e_load = 1; e_rd = 8;
        step("rw_load", C_NONE, 2'b00, 2'b00, 4'd0);
        clr_inputs();
        load_ack = 1;
        step("rw_imm_ack", C_NONE, 2'b00, 2'b00, 4'd0);
        clr_inputs();
        step("rw_run", C_NONE, 2'b00, 2'b00, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
